// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline port A has priority, and long-latency port B
// results are buffered in a small FIFO. Also publishes a pending-write scoreboard.
module wb_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_we,
  input  logic [4:0]  a_wa,
  input  logic [31:0] a_wd,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_wa,
  input  logic [31:0] b_wd,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic [31:0] pending,
  output logic        stall_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wb_entry_t;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve;

  logic        full, empty, push, pop, a_act, issue;
  logic [4:0]  sel_wa;
  logic [31:0] sel_wd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign b_ready = !full;
  assign stall_o = full && (starve == STV_W'(STARVE_LIMIT));

  // Writes to r0 are discarded at the input and never reach the FIFO or the output stage.
  assign push  = b_valid && b_ready && (b_wa != 5'd0);
  assign a_act = a_we && (a_wa != 5'd0) && !stall_o;
  assign pop   = !a_act && !empty;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    issue  = 1'b0;
    sel_wa = mem[rd_ptr].wa;
    sel_wd = mem[rd_ptr].wd;
    if (a_act) begin
      issue  = 1'b1;
      sel_wa = a_wa;
      sel_wd = a_wd;
    end else if (pop) begin
      issue = 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; entries are only read while the count marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{wa: b_wa, wd: b_wd};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The starvation counter measures how long a full FIFO has been blocked by port A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (pop) begin
      starve <= '0;
    end else if (full && a_act && (starve != STV_W'(STARVE_LIMIT))) begin
      starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= issue;
      if (issue) begin
        wa3 <= sel_wa;
        wd3 <= sel_wd;
      end
    end
  end

  // An entry is valid when its distance from the read pointer is below the occupancy count.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offs;
      offs = PTR_W'(i) - rd_ptr;
      if (CNT_W'(offs) < count) pending[mem[i].wa] = 1'b1;
    end
    if (we3) pending[wa3] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed testbench for wb_write_arbiter: each scenario task drives vectors and compares
// the outputs against hand-computed values.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] pending;
  logic        stall_o;

  int tests_run    = 0;
  int tests_failed = 0;

  wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_we    (a_we),
    .a_wa    (a_wa),
    .a_wd    (a_wd),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_wa    (b_wa),
    .b_wd    (b_wd),
    .we3     (we3),
    .wa3     (wa3),
    .wd3     (wd3),
    .pending (pending),
    .stall_o (stall_o)
  );

  always #5 clk = ~clk;

  // Hazard-unit rule: port A must not target a register still queued from port B.
  always @(negedge clk) begin
    if (!rst && a_we && a_wa != 5'd0)
      assert (!(pending[a_wa] && !(we3 && wa3 == a_wa)))
        else $error("port A write to r%0d while a port B write is queued", a_wa);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_we = 1'b0; a_wa = '0; a_wd = '0;
    b_valid = 1'b0; b_wa = '0; b_wd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({we3, wa3, wd3, pending, b_ready, stall_o} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: we3=%b wa3=%0d wd3=%h pending=%h b_ready=%b stall_o=%b, want 0/0/0/0/1/0",
               we3, wa3, wd3, pending, b_ready, stall_o);
    end
    tick(); tick();
    rst = 1'b0;
    // Queue two port-B entries behind a continuous port-A stream.
    a_we = 1'b1; a_wa = 5'd6; a_wd = 32'h0606_0606;
    b_valid = 1'b1; b_wa = 5'd2; b_wd = 32'h22;
    tick();
    b_wa = 5'd4; b_wd = 32'h44;
    tick();
    idle_inputs();
    tests_run++;
    if (pending !== 32'h0000_0054) begin
      tests_failed++;
      $display("FAIL reset_prequeue_pending: got %h want %h", pending, 32'h54);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (we3 !== 1'b0 || pending !== 32'd0 || b_ready !== 1'b1 || stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midcycle: we3=%b pending=%h b_ready=%b stall_o=%b, want 0/0/1/0",
               we3, pending, b_ready, stall_o);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (we3 !== 1'b0 || pending !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_idle_after_release[%0d]: we3=%b pending=%h want 0/0", i, we3, pending);
      end
    end
  endtask

  task automatic test_port_a();
    a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    tests_run++;
    if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 32'hDEAD_BEEF || pending !== 32'h20) begin
      tests_failed++;
      $display("FAIL port_a_issue: we3=%b wa3=%0d wd3=%h pending=%h want 1/5/deadbeef/20",
               we3, wa3, wd3, pending);
    end
    tick();
    tests_run++;
    if (we3 !== 1'b0 || pending !== 32'd0 || wa3 !== 5'd5) begin
      tests_failed++;
      $display("FAIL port_a_clear: we3=%b pending=%h wa3=%0d want 0/0/5", we3, pending, wa3);
    end
  endtask

  task automatic test_port_b_drain();
    b_valid = 1'b1; b_wa = 5'd3; b_wd = 32'h11;
    tick();
    b_wa = 5'd7; b_wd = 32'h22;
    tests_run++;
    if (we3 !== 1'b0 || pending !== 32'h8) begin
      tests_failed++;
      $display("FAIL drain_queued: we3=%b pending=%h want 0/8", we3, pending);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (we3 !== 1'b1 || wa3 !== 5'd3 || wd3 !== 32'h11 || pending !== 32'h88) begin
      tests_failed++;
      $display("FAIL drain_first: we3=%b wa3=%0d wd3=%h pending=%h want 1/3/11/88", we3, wa3, wd3, pending);
    end
    tick();
    tests_run++;
    if (we3 !== 1'b1 || wa3 !== 5'd7 || wd3 !== 32'h22 || pending !== 32'h80) begin
      tests_failed++;
      $display("FAIL drain_second: we3=%b wa3=%0d wd3=%h pending=%h want 1/7/22/80", we3, wa3, wd3, pending);
    end
    tick();
    tests_run++;
    if (we3 !== 1'b0 || pending !== 32'd0) begin
      tests_failed++;
      $display("FAIL drain_done: we3=%b pending=%h want 0/0", we3, pending);
    end
  endtask

  task automatic test_full_backpressure();
    logic [31:0] drain_pend [5];
    drain_pend = '{32'h7800, 32'h7000, 32'h6000, 32'h4000, 32'h0};
    a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h9999_0000;
    b_valid = 1'b1; b_wa = 5'd10; b_wd = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      tick();
      b_wa = 5'(11 + i); b_wd = 32'(32'hB1 + i);
    end
    tests_run++;
    if (b_ready !== 1'b0 || pending !== 32'h3E00 || we3 !== 1'b1 || wa3 !== 5'd9 || stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_reached: b_ready=%b pending=%h we3=%b wa3=%0d stall_o=%b want 0/3e00/1/9/0",
               b_ready, pending, we3, wa3, stall_o);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      tests_run++;
      if (stall_o !== 1'b0 || b_ready !== 1'b0 || we3 !== 1'b1 || wa3 !== 5'd9) begin
        tests_failed++;
        $display("FAIL full_starving[%0d]: stall_o=%b b_ready=%b we3=%b wa3=%0d want 0/0/1/9",
                 i, stall_o, b_ready, we3, wa3);
      end
    end
    tick();
    tests_run++;
    if (stall_o !== 1'b1 || b_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_stall_raised: stall_o=%b b_ready=%b want 1/0", stall_o, b_ready);
    end
    tick();
    tests_run++;
    if (stall_o !== 1'b0 || b_ready !== 1'b1 || we3 !== 1'b1 || wa3 !== 5'd10 || wd3 !== 32'hB0
        || pending !== 32'h3C00) begin
      tests_failed++;
      $display("FAIL full_head_written: stall_o=%b b_ready=%b we3=%b wa3=%0d wd3=%h pending=%h want 0/1/1/10/b0/3c00",
               stall_o, b_ready, we3, wa3, wd3, pending);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (we3 !== 1'b1 || wa3 !== 5'd9 || b_ready !== 1'b0 || pending !== 32'h7A00) begin
      tests_failed++;
      $display("FAIL full_fifth_accepted: we3=%b wa3=%0d b_ready=%b pending=%h want 1/9/0/7a00",
               we3, wa3, b_ready, pending);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (we3 !== (i < 4) || (i < 4 && (wa3 !== 5'(11 + i) || wd3 !== 32'(32'hB1 + i)))
          || pending !== drain_pend[i]) begin
        tests_failed++;
        $display("FAIL full_drain[%0d]: we3=%b wa3=%0d wd3=%h pending=%h want pending %h",
                 i, we3, wa3, wd3, pending, drain_pend[i]);
      end
    end
  endtask

  task automatic test_r0_filter();
    a_we = 1'b1; a_wa = 5'd0; a_wd = 32'h1234_5678;
    tick();
    idle_inputs();
    b_valid = 1'b1; b_wa = 5'd0; b_wd = 32'hCAFE;
    tests_run++;
    if (we3 !== 1'b0 || pending !== 32'd0 || b_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL r0_port_a: we3=%b pending=%h b_ready=%b want 0/0/1", we3, pending, b_ready);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (we3 !== 1'b0 || pending !== 32'd0 || b_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL r0_port_b[%0d]: we3=%b pending=%h b_ready=%b want 0/0/1", i, we3, pending, b_ready);
      end
      tick();
    end
  endtask

  task automatic test_wrap_around();
    logic [31:0] exp_pend;
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        b_valid = 1'b1; b_wa = 5'(k + 1); b_wd = 32'(32'h100 + k + 1);
      end else begin
        idle_inputs();
      end
      tick();
      exp_pend = (k < 10) ? (32'd1 << (k + 1)) : 32'd0;
      if (k > 0) exp_pend = exp_pend | (32'd1 << k);
      tests_run++;
      if (b_ready !== 1'b1 || we3 !== (k > 0) || pending !== exp_pend
          || (k > 0 && (wa3 !== 5'(k) || wd3 !== 32'(32'h100 + k)))) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: b_ready=%b we3=%b wa3=%0d wd3=%h pending=%h want pending %h",
                 k, b_ready, we3, wa3, wd3, pending, exp_pend);
      end
    end
    tick();
    tests_run++;
    if (we3 !== 1'b0 || pending !== 32'd0) begin
      tests_failed++;
      $display("FAIL wrap_done: we3=%b pending=%h want 0/0", we3, pending);
    end
  endtask

  initial begin
    test_reset();
    test_port_a();
    test_port_b_drain();
    test_full_backpressure();
    test_r0_filter();
    test_wrap_around();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
